// File: rtl/pipeline_seq_ctrl_if.sv
// pipeline_seq_ctrl_if
// Bundles the hazard inputs, debug run/step handshake and pipeline control
// outputs of the front-end sequencer.
//   master : the sequencer (consumes In_*, drives Out_*)
//   slave  : the pipeline datapath / debug unit side (the reverse)
interface pipeline_seq_ctrl_if;
  logic       In_Run;
  logic       In_StepReq;
  logic       Out_StepAck;
  logic [4:0] In_ID_Rs;
  logic [4:0] In_ID_Rt;
  logic       In_EX_MemRead;
  logic [4:0] In_EX_Rt;
  logic       In_BranchTaken;
  logic       In_HaltDetected;
  logic       Out_PCWrite;
  logic       Out_IFID_Enable;
  logic       Out_IFID_Flush;
  logic       Out_IDEX_Bubble;
  logic       Out_PipeEnable;
  logic       Out_Halted;
  logic [2:0] Out_State;

  modport master (
    input  In_Run, In_StepReq, In_ID_Rs, In_ID_Rt, In_EX_MemRead, In_EX_Rt,
           In_BranchTaken, In_HaltDetected,
    output Out_StepAck, Out_PCWrite, Out_IFID_Enable, Out_IFID_Flush,
           Out_IDEX_Bubble, Out_PipeEnable, Out_Halted, Out_State
  );

  modport slave (
    output In_Run, In_StepReq, In_ID_Rs, In_ID_Rt, In_EX_MemRead, In_EX_Rt,
           In_BranchTaken, In_HaltDetected,
    input  Out_StepAck, Out_PCWrite, Out_IFID_Enable, Out_IFID_Flush,
           Out_IDEX_Bubble, Out_PipeEnable, Out_Halted, Out_State
  );
endinterface

// File: rtl/pipeline_seq_ctrl.sv
// pipeline_seq_ctrl
// Front-end sequencer and hazard controller for the 5-stage MIPS pipeline.
// Resolves load-use stalls, taken-branch flushes and HALT draining, and lets
// the debug unit run the pipeline continuously or single-step it.
// Ports:
//   Clock : system clock, all state updates on posedge
//   Reset : asynchronous, active-high; forces IDLE
//   bus   : pipeline_seq_ctrl_if.master (hazard inputs, run/step handshake,
//           PC / IF-ID / ID-EX / pipe enables, halted flag, state readout)
// Control outputs are combinational from state and inputs; Out_StepAck,
// Out_Halted and Out_State are registered.
module pipeline_seq_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  pipeline_seq_ctrl_if.master        bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_e     state_r;
  state_e     state_next_s;
  logic [3:0] drain_cnt_r;
  logic       step_ack_r;
  logic       halted_r;

  logic       load_use_s;
  logic       pc_write_s;
  logic       ifid_enable_s;
  logic       ifid_flush_s;
  logic       idex_bubble_s;
  logic       pipe_enable_s;

  // Load in EX whose destination feeds the instruction in ID; r0 never hazards.
  assign load_use_s = bus.In_EX_MemRead && (bus.In_EX_Rt != 5'd0) &&
                      ((bus.In_EX_Rt == bus.In_ID_Rs) || (bus.In_EX_Rt == bus.In_ID_Rt));

  // Next-state and combinational pipeline control.
  always_comb begin
    state_next_s  = state_r;
    pc_write_s    = 1'b0;
    ifid_enable_s = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    pipe_enable_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.In_Run) begin
          state_next_s = ST_RUN;
        end else if (bus.In_StepReq) begin
          state_next_s = ST_STEP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        // Advance cycle: run/step exit first, a halt may then override it.
        if ((state_r == ST_RUN) && bus.In_Run) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
        pipe_enable_s = 1'b1;
        if (load_use_s) begin
          idex_bubble_s = 1'b1;
        end else if (bus.In_HaltDetected) begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
          state_next_s  = ST_DRAIN;
        end else if (bus.In_BranchTaken) begin
          pc_write_s    = 1'b1;
          ifid_enable_s = 1'b1;
          ifid_flush_s  = 1'b1;
        end else begin
          pc_write_s    = 1'b1;
          ifid_enable_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        pipe_enable_s = 1'b1;
        idex_bubble_s = 1'b1;
        if (drain_cnt_r == DRAIN_LAST) begin
          state_next_s = ST_HALTED;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        state_next_s = ST_HALTED;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, drain counter and registered status outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 4'd0;
      step_ack_r  <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      // Counter is 0 on the first DRAIN cycle and counts while draining.
      if (state_r == ST_DRAIN) begin
        drain_cnt_r <= drain_cnt_r + 4'd1;
      end else begin
        drain_cnt_r <= 4'd0;
      end
      // STEP always lasts one cycle, whichever state it leaves to.
      step_ack_r <= (state_r == ST_STEP);
      halted_r   <= (state_next_s == ST_HALTED);
    end
  end

  assign bus.Out_PCWrite     = pc_write_s;
  assign bus.Out_IFID_Enable = ifid_enable_s;
  assign bus.Out_IFID_Flush  = ifid_flush_s;
  assign bus.Out_IDEX_Bubble = idex_bubble_s;
  assign bus.Out_PipeEnable  = pipe_enable_s;
  assign bus.Out_StepAck     = step_ack_r;
  assign bus.Out_Halted      = halted_r;
  assign bus.Out_State       = state_r;

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// tb_pipeline_seq_ctrl
// Directed-vector bench with a scoreboard: each vector pushes its
// hand-computed expected outputs; a monitor pops and compares every cycle.
// Expected word: {PCWrite, IFID_Enable, IFID_Flush, IDEX_Bubble, PipeEnable,
//                 Halted, StepAck, State[2:0]}
module tb_pipeline_seq_ctrl;

  logic clk   = 1'b0;
  logic Reset = 1'b1;

  pipeline_seq_ctrl_if bus_if ();

  pipeline_seq_ctrl #(.DRAIN_CYCLES(4)) dut (
    .Clock (clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  // Monitor: outputs are stable at the falling edge for the cycle just driven.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [9:0] act;
      e   = exp_q.pop_front();
      act = {bus_if.Out_PCWrite, bus_if.Out_IFID_Enable, bus_if.Out_IFID_Flush,
             bus_if.Out_IDEX_Bubble, bus_if.Out_PipeEnable, bus_if.Out_Halted,
             bus_if.Out_StepAck, bus_if.Out_State};
      checks_total = checks_total + 1;
      if (act === e.v) begin
        checks_passed = checks_passed + 1;
      end else begin
        $display("FAIL %s: got %b expected %b", e.name, act, e.v);
      end
    end
  end

  // One clock of stimulus, applied just after the rising edge.
  task automatic vec(input string name, input logic rst, input logic run,
                     input logic sreq, input logic ld, input logic [4:0] ex_rt,
                     input logic [4:0] rs, input logic [4:0] rt, input logic br,
                     input logic halt, input logic [9:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    Reset                  = rst;
    bus_if.In_Run          = run;
    bus_if.In_StepReq      = sreq;
    bus_if.In_EX_MemRead   = ld;
    bus_if.In_EX_Rt        = ex_rt;
    bus_if.In_ID_Rs        = rs;
    bus_if.In_ID_Rt        = rt;
    bus_if.In_BranchTaken  = br;
    bus_if.In_HaltDetected = halt;
    x.v    = e;
    x.name = name;
    exp_q.push_back(x);
  endtask

  initial begin
    bus_if.In_Run          = 1'b0;
    bus_if.In_StepReq      = 1'b0;
    bus_if.In_EX_MemRead   = 1'b0;
    bus_if.In_EX_Rt        = 5'd0;
    bus_if.In_ID_Rs        = 5'd0;
    bus_if.In_ID_Rt        = 5'd0;
    bus_if.In_BranchTaken  = 1'b0;
    bus_if.In_HaltDetected = 1'b0;

    //   name               rst  run  sreq ld   ex_rt rs    rt    br   halt  expected
    vec("reset",            1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_00_000);
    vec("idle_run_rise",    1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_00_000);
    vec("run_normal",       1'b0,1'b1,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0, 10'b11001_00_001);
    vec("load_use_rs",      1'b0,1'b1,1'b0,1'b1,5'd5, 5'd5, 5'd2, 1'b0,1'b0, 10'b00011_00_001);
    vec("after_stall",      1'b0,1'b1,1'b0,1'b0,5'd5, 5'd5, 5'd2, 1'b0,1'b0, 10'b11001_00_001);
    vec("rt0_no_stall",     1'b0,1'b1,1'b0,1'b1,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b11001_00_001);
    vec("load_use_rt",      1'b0,1'b1,1'b0,1'b1,5'd7, 5'd1, 5'd7, 1'b0,1'b0, 10'b00011_00_001);
    vec("stall_beats_br",   1'b0,1'b1,1'b0,1'b1,5'd3, 5'd3, 5'd4, 1'b1,1'b0, 10'b00011_00_001);
    vec("branch",           1'b0,1'b1,1'b0,1'b0,5'd3, 5'd3, 5'd4, 1'b1,1'b0, 10'b11101_00_001);
    vec("run_exit_adv",     1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b11001_00_001);
    vec("idle_sreq",        1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_00_000);
    vec("step_adv",         1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b11001_00_010);
    vec("step_ack",         1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_01_000);
    vec("idle_no_requeue",  1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_00_000);
    vec("idle_to_run",      1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_00_000);
    vec("halt_cycle",       1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1, 10'b00111_00_001);
    vec("drain0",           1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00011_00_011);
    vec("drain1_hazard",    1'b0,1'b1,1'b0,1'b1,5'd6, 5'd6, 5'd0, 1'b1,1'b1, 10'b00011_00_011);
    vec("drain2",           1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00011_00_011);
    vec("drain3",           1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00011_00_011);
    vec("halted",           1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_10_100);
    vec("halted_sticky",    1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_10_100);
    vec("reset_from_halt",  1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_00_000);
    vec("idle_run2",        1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_00_000);
    vec("halt_cycle2",      1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1, 10'b00111_00_001);
    vec("drain0_b",         1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00011_00_011);
    vec("drain1_b",         1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00011_00_011);
    vec("reset_mid_drain",  1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_00_000);
    vec("idle_after_rst",   1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_00_000);
    vec("run_after_rst",    1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b11001_00_001);
    vec("halt_cycle3",      1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1, 10'b00111_00_001);
    vec("drain0_c",         1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00011_00_011);
    vec("drain1_c",         1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00011_00_011);
    vec("drain2_c",         1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00011_00_011);
    vec("drain3_c",         1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00011_00_011);
    vec("halted_c",         1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_10_100);
    vec("reset_again",      1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_00_000);
    vec("idle_sreq2",       1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00000_00_000);
    vec("step_halt",        1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1, 10'b00111_00_010);
    vec("drain_step_ack",   1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0, 10'b00011_01_011);

    @(negedge clk);
    #1;
    checks_total = checks_total + 1;
    if (exp_q.size() == 0) begin
      checks_passed = checks_passed + 1;
    end else begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
